// File: rtl/pool_bank_pkg.sv
// Shared accelerator definitions: pooling mode encodings and a constant clog2 helper.
package pool_bank_pkg;

  localparam int MODE_MAX = 0;
  localparam int MODE_AVG = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/pool_bank_if.sv
// Sample-in / pooled-vector-out handshake bundle for pool_bank.
interface pool_bank_if
  import pool_bank_pkg::*;
#(
  parameter int N_CH   = 16,
  parameter int DATA_W = 16
);
  localparam int CH_W = clog2(N_CH);

  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_pix;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_CH*DATA_W-1:0]   out_data;
  logic                     err_seq;

  modport master (
    output in_valid, in_ch, in_pix, out_ready,
    input  in_ready, out_valid, out_data, err_seq
  );

  modport slave (
    input  in_valid, in_ch, in_pix, out_ready,
    output in_ready, out_valid, out_data, err_seq
  );

endinterface

// File: rtl/pool_lane.sv
// One channel of the pooling bank: optional ReLU, then max or running-sum accumulation.
module pool_lane
  import pool_bank_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int POOL_K  = 2,
  parameter int MODE    = 0,
  parameter int RELU_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic                     first,
  input  logic signed [DATA_W-1:0] pix,
  output logic [DATA_W-1:0]        result
);
  localparam int SHIFT = 2 * clog2(POOL_K);
  localparam int ACC_W = DATA_W + SHIFT;

  logic signed [DATA_W-1:0] sample;
  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;

  // result is taken from acc_next so the final sample of a window lands in the captured vector
  always_comb begin
    sample     = (RELU_EN != 0 && pix[DATA_W-1]) ? '0 : pix;
    sample_ext = {{SHIFT{sample[DATA_W-1]}}, sample};
    acc_next   = acc;
    if (sample_en) begin
      if (first) begin
        acc_next = sample_ext;
      end else if (MODE == MODE_AVG) begin
        acc_next = acc + sample_ext;
      end else if (sample_ext > acc) begin
        acc_next = sample_ext;
      end
    end
    if (MODE == MODE_AVG) begin
      result = DATA_W'(acc_next >>> SHIFT);
    end else begin
      result = DATA_W'(acc_next);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (sample_en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/pool_bank.sv
// Channel-interleaved pooling bank: samples arrive sub-sample-major and one pooled vector
// of N_CH results is emitted per window.
module pool_bank
  import pool_bank_pkg::*;
#(
  parameter int N_CH    = 16,
  parameter int DATA_W  = 16,
  parameter int POOL_K  = 2,
  parameter int MODE    = 0,
  parameter int RELU_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  pool_bank_if.slave bus
);
  localparam int CH_W = clog2(N_CH);
  localparam int SS_N = POOL_K * POOL_K;
  localparam int SS_W = clog2(SS_N);

  if (MODE == MODE_AVG && POOL_K == 3) begin : g_illegal_avg_k3
    $error("pool_bank: average pooling needs a power-of-two POOL_K (2 or 4)");
  end

  logic [CH_W-1:0]        ch_cnt;
  logic [SS_W-1:0]        ss_cnt;
  logic                   last_ch;
  logic                   last_ss;
  logic                   last_slot;
  logic                   accept;
  logic                   out_valid_q;
  logic                   err_q;
  logic [N_CH*DATA_W-1:0] out_data_q;
  logic [N_CH*DATA_W-1:0] results;

  assign last_ch   = (ch_cnt == CH_W'(N_CH - 1));
  assign last_ss   = (ss_cnt == SS_W'(SS_N - 1));
  assign last_slot = last_ch && last_ss;

  // Only the window-closing sample needs the output register, so only it waits on a stall
  assign bus.in_ready  = !(last_slot && out_valid_q && !bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err_seq   = err_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    pool_lane #(
      .DATA_W (DATA_W),
      .POOL_K (POOL_K),
      .MODE   (MODE),
      .RELU_EN(RELU_EN)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .sample_en(accept && (ch_cnt == CH_W'(c))),
      .first    (ss_cnt == '0),
      .pix      (bus.in_pix),
      .result   (results[c*DATA_W +: DATA_W])
    );
  end

  // Slot counters follow accepted samples; in_ch is only checked, never used for steering
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt      <= '0;
      ss_cnt      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept) begin
        if (last_ch) begin
          ch_cnt <= '0;
          ss_cnt <= last_ss ? '0 : ss_cnt + SS_W'(1);
        end else begin
          ch_cnt <= ch_cnt + CH_W'(1);
        end
        if (bus.in_ch != ch_cnt) err_q <= 1'b1;
      end
      if (accept && last_slot) begin
        out_data_q  <= results;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_bank.sv
// Bench for pool_bank: max, average and ReLU-max instances share one stimulus stream and
// are scored against table-derived expected vectors.
module tb_pool_bank;
  import pool_bank_pkg::*;

  localparam int N_CH   = 16;
  localparam int DATA_W = 16;
  localparam int SS_N   = 4;
  localparam int VEC_W  = N_CH * DATA_W;

  typedef logic [VEC_W-1:0] vec_t;
  typedef struct {
    int pix[SS_N];
    int exp_max;
    int exp_avg;
    int exp_relu;
  } vector_t;

  vector_t table_v[8];

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [3:0]        in_ch;
  logic signed [15:0] in_pix;
  logic              out_ready;

  int checks = 0;
  int errors = 0;

  vec_t q_max[$];
  vec_t q_avg[$];
  vec_t q_relu[$];

  pool_bank_if #(.N_CH(N_CH), .DATA_W(DATA_W)) if_max ();
  pool_bank_if #(.N_CH(N_CH), .DATA_W(DATA_W)) if_avg ();
  pool_bank_if #(.N_CH(N_CH), .DATA_W(DATA_W)) if_relu ();

  assign if_max.in_valid   = in_valid;
  assign if_max.in_ch      = in_ch;
  assign if_max.in_pix     = in_pix;
  assign if_max.out_ready  = out_ready;
  assign if_avg.in_valid   = in_valid;
  assign if_avg.in_ch      = in_ch;
  assign if_avg.in_pix     = in_pix;
  assign if_avg.out_ready  = out_ready;
  assign if_relu.in_valid  = in_valid;
  assign if_relu.in_ch     = in_ch;
  assign if_relu.in_pix    = in_pix;
  assign if_relu.out_ready = out_ready;

  pool_bank #(.N_CH(N_CH), .DATA_W(DATA_W), .POOL_K(2), .MODE(MODE_MAX), .RELU_EN(0))
    dut_max (.clk(clk), .rst(rst), .bus(if_max.slave));
  pool_bank #(.N_CH(N_CH), .DATA_W(DATA_W), .POOL_K(2), .MODE(MODE_AVG), .RELU_EN(0))
    dut_avg (.clk(clk), .rst(rst), .bus(if_avg.slave));
  pool_bank #(.N_CH(N_CH), .DATA_W(DATA_W), .POOL_K(2), .MODE(MODE_MAX), .RELU_EN(1))
    dut_relu (.clk(clk), .rst(rst), .bus(if_relu.slave));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input vec_t actual, input vec_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got an output vector, expected none queued", name);
  endtask

  // Each completed handshake retires the oldest expected vector of that instance
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (if_max.out_valid) begin
        if (q_max.size() == 0) reportUnexpected("max_vec");
        else checkOutput("max_vec", if_max.out_data, q_max.pop_front());
      end
      if (if_avg.out_valid) begin
        if (q_avg.size() == 0) reportUnexpected("avg_vec");
        else checkOutput("avg_vec", if_avg.out_data, q_avg.pop_front());
      end
      if (if_relu.out_valid) begin
        if (q_relu.size() == 0) reportUnexpected("relu_vec");
        else checkOutput("relu_vec", if_relu.out_data, q_relu.pop_front());
      end
    end
  end

  function automatic vector_t makeRow(input int a, input int b, input int c, input int d,
                                      input int em, input int ea, input int er);
    vector_t r;
    r.pix[0] = a; r.pix[1] = b; r.pix[2] = c; r.pix[3] = d;
    r.exp_max = em; r.exp_avg = ea; r.exp_relu = er;
    return r;
  endfunction

  function automatic vec_t packVec(input int v[N_CH]);
    vec_t r;
    r = '0;
    for (int c = 0; c < N_CH; c++) r[c*DATA_W +: DATA_W] = 16'(v[c]);
    return r;
  endfunction

  // Caller is at posedge+1; returns at posedge+1 right after the sample was accepted
  task automatic applyStimulus(input int pix, input int ch);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_pix   = 16'(pix);
    in_ch    = 4'(ch);
    @(negedge clk);
    while (!if_max.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!if_max.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready got 0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic buildTableWindow(input int w, output int smp[SS_N][N_CH],
                                  output vec_t em, output vec_t ea, output vec_t er);
    int vm[N_CH];
    int va[N_CH];
    int vr[N_CH];
    for (int c = 0; c < N_CH; c++) begin
      for (int s = 0; s < SS_N; s++) smp[s][c] = table_v[(c + w) % 8].pix[s];
      vm[c] = table_v[(c + w) % 8].exp_max;
      va[c] = table_v[(c + w) % 8].exp_avg;
      vr[c] = table_v[(c + w) % 8].exp_relu;
    end
    em = packVec(vm);
    ea = packVec(va);
    er = packVec(vr);
  endtask

  // Expectations are queued just before the window-closing sample is driven
  task automatic sendWindow(input int smp[SS_N][N_CH], input vec_t em, input vec_t ea,
                            input vec_t er, input int bad_ss, input int bad_ch);
    for (int s = 0; s < SS_N; s++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (s == SS_N - 1 && c == N_CH - 1) begin
          q_max.push_back(em);
          q_avg.push_back(ea);
          q_relu.push_back(er);
        end
        applyStimulus(smp[s][c], (s == bad_ss && c == bad_ch) ? c + 1 : c);
      end
    end
  endtask

  task automatic checkDrained(input string name);
    checkOutput(name, vec_t'(q_max.size() + q_avg.size() + q_relu.size()), '0);
  endtask

  initial begin
    int   smp[SS_N][N_CH];
    int   vm[N_CH];
    int   va[N_CH];
    vec_t em, ea, er, em2, ea2, er2;

    table_v[0] = makeRow(4, 5, 6, 7, 7, 5, 7);
    table_v[1] = makeRow(-1, -1, -1, -2, -1, -2, 0);
    table_v[2] = makeRow(-100, -100, -100, -100, -100, -100, 0);
    table_v[3] = makeRow(32767, 32767, 32767, 32767, 32767, 32767, 32767);
    table_v[4] = makeRow(-32768, -32768, -32768, -32768, -32768, -32768, 0);
    table_v[5] = makeRow(3, -7, 0, -2, 3, -2, 3);
    table_v[6] = makeRow(-9, -3, -8, -4, -3, -6, 0);
    table_v[7] = makeRow(0, 1, 2, 1, 2, 1, 2);

    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_pix = '0; out_ready = 1'b1;
    #12;
    checkOutput("reset_out_valid", vec_t'(if_max.out_valid), '0);
    checkOutput("reset_out_data", if_avg.out_data, '0);
    checkOutput("reset_err_seq", vec_t'(if_max.err_seq), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", vec_t'(if_max.in_ready), vec_t'(1));
    @(posedge clk); #1;

    // Reference window: ch c = {c, -5, 3c, 2}
    for (int c = 0; c < N_CH; c++) begin
      smp[0][c] = c; smp[1][c] = -5; smp[2][c] = 3 * c; smp[3][c] = 2;
      vm[c] = (c == 0) ? 2 : 3 * c;
      va[c] = c - 1;
    end
    em = packVec(vm);
    ea = packVec(va);
    sendWindow(smp, em, ea, em, -1, -1);
    @(negedge clk);
    checkOutput("pulse_high", vec_t'(if_max.out_valid), vec_t'(1));
    @(negedge clk);
    checkOutput("pulse_low", vec_t'(if_max.out_valid), '0);
    @(posedge clk); #1;

    for (int c = 0; c < N_CH; c++) begin
      for (int s = 0; s < SS_N; s++) smp[s][c] = -100;
      vm[c] = -100;
      va[c] = 0;
    end
    sendWindow(smp, packVec(vm), packVec(vm), packVec(va), -1, -1);

    for (int w = 0; w < 3; w++) begin
      buildTableWindow(w, smp, em, ea, er);
      sendWindow(smp, em, ea, er, -1, -1);
    end
    repeat (2) @(posedge clk); #1;
    checkDrained("queues_after_table");

    // Stall: both windows arrive with out_ready low; the second waits at its last slot
    out_ready = 1'b0;
    buildTableWindow(3, smp, em, ea, er);
    sendWindow(smp, em, ea, er, -1, -1);
    buildTableWindow(4, smp, em2, ea2, er2);
    for (int s = 0; s < SS_N; s++)
      for (int c = 0; c < N_CH; c++)
        if (!(s == SS_N - 1 && c == N_CH - 1)) applyStimulus(smp[s][c], c);
    q_max.push_back(em2); q_avg.push_back(ea2); q_relu.push_back(er2);
    in_valid = 1'b1; in_pix = 16'(smp[SS_N-1][N_CH-1]); in_ch = 4'(N_CH - 1);
    repeat (3) @(negedge clk);
    checkOutput("stall_in_ready", vec_t'(if_max.in_ready), '0);
    checkOutput("stall_out_valid", vec_t'(if_avg.out_valid), vec_t'(1));
    checkOutput("stall_hold_max", if_max.out_data, em);
    checkOutput("stall_hold_avg", if_avg.out_data, ea);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", vec_t'(if_max.in_ready), vec_t'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("release_second_valid", vec_t'(if_relu.out_valid), vec_t'(1));
    @(posedge clk); #1;
    checkDrained("queues_after_stall");

    // in_ch 7 presented in slot (0, 6); pooling must still follow slot order
    checkOutput("err_before", vec_t'(if_max.err_seq), '0);
    buildTableWindow(5, smp, em, ea, er);
    sendWindow(smp, em, ea, er, 0, 6);
    checkOutput("err_set_max", vec_t'(if_max.err_seq), vec_t'(1));
    checkOutput("err_set_avg", vec_t'(if_avg.err_seq), vec_t'(1));
    buildTableWindow(6, smp, em, ea, er);
    sendWindow(smp, em, ea, er, -1, -1);
    @(negedge clk);
    checkOutput("err_sticky", vec_t'(if_max.err_seq), vec_t'(1));
    @(posedge clk); #1;

    // Partial window of 30 samples, then an asynchronous reset mid-cycle
    buildTableWindow(7, smp, em, ea, er);
    for (int i = 0; i < 30; i++) applyStimulus(smp[i / N_CH][i % N_CH], i % N_CH);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_out_data", if_max.out_data, '0);
    checkOutput("async_rst_out_valid", vec_t'(if_avg.out_valid), '0);
    checkOutput("async_rst_err_seq", vec_t'(if_max.err_seq), '0);
    #3 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_in_ready", vec_t'(if_max.in_ready), vec_t'(1));
    @(posedge clk); #1;
    buildTableWindow(2, smp, em, ea, er);
    sendWindow(smp, em, ea, er, -1, -1);
    repeat (3) @(posedge clk); #1;
    checkDrained("queues_final");
    checkOutput("final_err_clear", vec_t'(if_relu.err_seq), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_bank.md
POOL_BANK -- requirements
Module: pool_bank

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_CH, 16, number of channels per pooling window (2..64).
- DATA_W, 16, signed sample width.
- POOL_K, 2, pooling window side; samples per window = POOL_K*POOL_K (2..4).
- MODE, 0, 0 = max pool, 1 = average pool (POOL_K in {2,4} only).
- RELU_EN, 1, 1 = clamp negative input samples to 0 before pooling.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- in_valid, in, 1, input sample valid.
- in_ready, out, 1, input sample accepted when in_valid & in_ready.
- in_ch, in, CH_W = clog2(N_CH), channel index of the sample.
- in_pix, in, DATA_W, signed sample.
- out_valid, out, 1, pooled vector valid.
- out_ready, in, 1, downstream accepts the vector.
- out_data, out, N_CH*DATA_W, channel c at bits [c*DATA_W +: DATA_W].
- err_seq, out, 1, sticky channel-order error flag.

Function
REQ-003 The block SHALL accept input in sub-sample-major order: for ss = 0..POOL_K^2-1, channels 0..N_CH-1 in ascending order.
REQ-004 Internal counters ch_cnt (0..N_CH-1) and ss_cnt (0..POOL_K^2-1) SHALL advance only on accepted samples; ch_cnt wraps to 0 and increments ss_cnt; ss_cnt wraps to 0 after the last window slot.
REQ-005 An accepted sample SHALL be applied to channel ch_cnt; if in_ch != ch_cnt, err_seq SHALL be set and held until reset.
REQ-006 With RELU_EN = 1, negative samples SHALL be replaced by 0 before pooling.
REQ-007 Max mode: at ss = 0 the sample SHALL load the channel accumulator; at later ss the accumulator SHALL take the signed maximum.
REQ-008 Average mode: the accumulator width SHALL be DATA_W + 2*clog2(POOL_K); ss = 0 loads, later ss adds; the result SHALL be the sum arithmetically shifted right by 2*clog2(POOL_K), i.e. floor division with no saturation.
REQ-009 On acceptance of the last slot (ss = POOL_K^2-1, ch = N_CH-1), out_data SHALL capture all N_CH final results, including the result for that same last sample, and out_valid SHALL assert on the next cycle (latency 1).
REQ-010 out_data and out_valid SHALL hold stable while out_valid & !out_ready; out_valid clears on the cycle after out_valid & out_ready unless a new last-slot sample is accepted in that same cycle, in which case new data loads and out_valid stays high.
REQ-011 in_ready SHALL be 1 except when the next expected slot is the last slot and out_valid & !out_ready; non-last samples of the next window are accepted while the output is stalled.
REQ-012 An illegal parameter combination (MODE = 1 with POOL_K = 3) SHALL be rejected at elaboration.

Reset
REQ-013 Asserting rst SHALL immediately clear ch_cnt, ss_cnt, out_valid, err_seq and out_data to 0, and all accumulators to 0.
REQ-014 Reset in the middle of a window SHALL discard the partial window; the first accepted sample after reset is slot (ss 0, ch 0).
REQ-015 After rst deasserts, in_ready SHALL be 1.

Structure
REQ-016 MODE_MAX/MODE_AVG encodings and the clog2 function SHALL live in the shared accelerator package/include; CH_W and the accumulator width are derived locally.
REQ-017 One sub-module, pool_lane (per-channel accumulator, max/avg, ReLU), SHALL be instantiated N_CH times via generate.

Verification
REQ-018 The bench SHALL cover these directed scenarios (N_CH = 16, DATA_W = 16, POOL_K = 2 unless noted):
- Max, RELU_EN = 0, ch c samples {c, -5, 3c, 2}, out_ready = 1 -> one out_valid pulse 1 cycle after the 64th sample; ch c = max(3c, 2); ch0 = 2.
- Avg, ch0 samples {4, 5, 6, 7} -> ch0 = 5 (22 >> 2); samples {-1, -1, -1, -2} -> -2.
- RELU_EN = 1, max, all samples -100 -> all channels 0.
- out_ready = 0 across two windows -> second window stalls with in_ready = 0 at slot (3, 15); first vector held unchanged; releasing out_ready delivers the second vector with no loss.
- in_ch = 7 sent in slot ch 6 -> err_seq = 1 and stays 1 until rst; pooling uses slot order.
- rst pulsed asynchronously after 30 samples -> outputs 0 immediately; a fresh 64-sample window yields correct results.
